// File: rtl/rename_map_table.sv
// Register rename map: a speculative and a committed areg->preg table with one registered output stage.
// Optional RENAME_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.

`ifndef NUM_PREGS
`define NUM_PREGS 128
`endif
`ifndef RENAME_WIDTH
`define RENAME_WIDTH 2
`endif

module rename_map_table #(
  parameter int unsigned NUM_AREGS    = 32,
  parameter int unsigned NUM_PREGS    = `NUM_PREGS,
  parameter int unsigned RENAME_WIDTH = `RENAME_WIDTH,
  localparam int AW = $clog2(NUM_AREGS),
  localparam int PW = $clog2(NUM_PREGS),
  localparam int W  = RENAME_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [W-1:0]    ren_valid,
  input  logic [W-1:0]    ren_rd_we,
  input  logic [AW*W-1:0] ren_rd,
  input  logic [AW*W-1:0] ren_rs1,
  input  logic [AW*W-1:0] ren_rs2,
  input  logic [PW*W-1:0] free_preg,
  input  logic            free_empty,
  output logic            free_r_en,
  output logic            ren_ready,
  output logic [W-1:0]    out_valid,
  output logic [PW*W-1:0] out_prs1,
  output logic [PW*W-1:0] out_prs2,
  output logic [PW*W-1:0] out_prd,
  output logic [PW*W-1:0] out_old_prd,
  output logic [W-1:0]    recycle_valid,
  output logic [PW*W-1:0] recycle_preg,
  input  logic            out_ready,
  input  logic [W-1:0]    commit_valid,
  input  logic [AW*W-1:0] commit_rd,
  input  logic [PW*W-1:0] commit_prd,
  input  logic            flush
`ifdef RENAME_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  logic [PW-1:0] smap_q [NUM_AREGS];
  logic [PW-1:0] smap_d [NUM_AREGS];
  logic [PW-1:0] cmap_q [NUM_AREGS];
  logic [PW-1:0] cmap_d [NUM_AREGS];

  logic [AW-1:0] rd_s  [W];
  logic [AW-1:0] rs1_s [W];
  logic [AW-1:0] rs2_s [W];
  logic [AW-1:0] crd_s [W];
  logic [PW-1:0] fp_s  [W];
  logic [PW-1:0] cprd_s[W];

  logic [W-1:0]    wr;
  logic            accept;
  logic [PW*W-1:0] prs1_d, prs2_d, prd_d, old_d;
  logic [PW-1:0]   p1, p2, po;

  logic [W-1:0]    out_valid_q, recycle_valid_q;
  logic [PW*W-1:0] prs1_q, prs2_q, prd_q, old_q, recycle_preg_q;

  always_comb begin
    for (int i = 0; i < W; i++) begin
      rd_s[i]   = ren_rd[i*AW +: AW];
      rs1_s[i]  = ren_rs1[i*AW +: AW];
      rs2_s[i]  = ren_rs2[i*AW +: AW];
      crd_s[i]  = commit_rd[i*AW +: AW];
      fp_s[i]   = free_preg[i*PW +: PW];
      cprd_s[i] = commit_prd[i*PW +: PW];
    end
  end

  always_comb begin
    wr = '0;
    for (int i = 0; i < W; i++) begin
      wr[i] = ren_valid[i] & ren_rd_we[i] & (rd_s[i] != '0);
    end
  end

  assign ren_ready = rst & ~free_empty & ~flush & (~|out_valid_q | out_ready);
  assign accept    = ren_ready & |ren_valid;
  assign free_r_en = accept;

  // Intra-group bypass: scanning older slots in ascending order leaves the youngest match.
  always_comb begin
    prs1_d = '0;
    prs2_d = '0;
    prd_d  = '0;
    old_d  = '0;
    p1     = '0;
    p2     = '0;
    po     = '0;
    for (int i = 0; i < W; i++) begin
      p1 = smap_q[rs1_s[i]];
      p2 = smap_q[rs2_s[i]];
      po = smap_q[rd_s[i]];
      for (int j = 0; j < W; j++) begin
        if (j < i && wr[j]) begin
          if (rd_s[j] == rs1_s[i]) p1 = fp_s[j];
          if (rd_s[j] == rs2_s[i]) p2 = fp_s[j];
          if (rd_s[j] == rd_s[i])  po = fp_s[j];
        end
      end
      if (rs1_s[i] == '0) p1 = '0;
      if (rs2_s[i] == '0) p2 = '0;
      prs1_d[i*PW +: PW] = p1;
      prs2_d[i*PW +: PW] = p2;
      prd_d[i*PW +: PW]  = wr[i] ? fp_s[i] : '0;
      old_d[i*PW +: PW]  = wr[i] ? po : '0;
    end
  end

  // Commits land first so a same-cycle flush restores them too.
  always_comb begin
    cmap_d = cmap_q;
    for (int i = 0; i < W; i++) begin
      if (commit_valid[i] && crd_s[i] != '0) cmap_d[crd_s[i]] = cprd_s[i];
    end
    smap_d = smap_q;
    if (flush) begin
      smap_d = cmap_d;
    end else if (accept) begin
      for (int i = 0; i < W; i++) begin
        if (wr[i]) smap_d[rd_s[i]] = fp_s[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        smap_q[i] <= PW'(i);
        cmap_q[i] <= PW'(i);
      end
      out_valid_q     <= '0;
      recycle_valid_q <= '0;
      prs1_q          <= '0;
      prs2_q          <= '0;
      prd_q           <= '0;
      old_q           <= '0;
      recycle_preg_q  <= '0;
    end else begin
      smap_q          <= smap_d;
      cmap_q          <= cmap_d;
      recycle_valid_q <= '0;
      if (flush) begin
        out_valid_q <= '0;
      end else if (accept) begin
        out_valid_q     <= ren_valid;
        prs1_q          <= prs1_d;
        prs2_q          <= prs2_d;
        prd_q           <= prd_d;
        old_q           <= old_d;
        recycle_valid_q <= ~wr;
        recycle_preg_q  <= free_preg;
      end else if (out_ready) begin
        out_valid_q <= '0;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_prs1      = prs1_q;
  assign out_prs2      = prs2_q;
  assign out_prd       = prd_q;
  assign out_old_prd   = old_q;
  assign recycle_valid = recycle_valid_q;
  assign recycle_preg  = recycle_preg_q;

`ifdef RENAME_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (|ren_valid && !ren_ready && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
